// File: rtl/halt_monitor_pkg.sv
// ============================================================================
// Module      : halt_monitor_pkg
// Description : Shared state encoding, halt-pattern constants and helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package halt_monitor_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SEND_CYC = 2'd1,
    SEND_RET = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [31:0] HALT_INSTR   = 32'h0000_006F;  // jal x0, 0
  localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;
  localparam int          RUN_CNT_W    = 4;

  function automatic logic is_halt_pattern(input logic [31:0] fetch_i,
                                           input logic [31:0] decode_i);
    return (fetch_i == HALT_INSTR) && (decode_i == BUBBLE_INSTR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/halt_monitor_sat_counter.sv
// ============================================================================
// Module      : sat_counter
// Description : Enabled up-counter that sticks at all-ones instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/halt_monitor.sv
// ============================================================================
// Module      : halt_monitor
// Description : Counts cycles/retirements until halt pattern or timeout, then
//               streams the two counts out over a valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module halt_monitor
  import halt_monitor_pkg::*;
#(
  parameter int          CNT_W        = 32,
  parameter int          HALT_CONFIRM = 1,
  parameter logic [31:0] MAX_CYCLES   = 32'd5000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      fetch_instruction,
  input  logic [31:0]      decode_instruction,
  input  logic             retire_valid,
  output logic             halted,
  output logic             timeout,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [CNT_W-1:0] rpt_data,
  output logic             rpt_last
);

  localparam logic [CNT_W-1:0]     c_cyc_limit = CNT_W'(MAX_CYCLES - 32'd1);
  localparam logic [RUN_CNT_W-1:0] c_confirm   = RUN_CNT_W'(HALT_CONFIRM);

  state_t                 r_state;
  state_t                 w_state_next;
  logic [RUN_CNT_W-1:0]   r_run_cnt;
  logic [RUN_CNT_W-1:0]   w_run_next;
  logic [CNT_W-1:0]       r_cyc_latch;
  logic                   r_timeout;
  logic [CNT_W-1:0]       w_cycles;
  logic [CNT_W-1:0]       w_retired;
  logic                   w_run;
  logic                   w_pattern;
  logic                   w_halt_hit;
  logic                   w_time_hit;

  assign w_run     = (r_state == RUN);
  assign w_pattern = is_halt_pattern(fetch_instruction, decode_instruction);

  // Run length of consecutive pattern cycles, sticking at its maximum.
  always_comb begin
    w_run_next = '0;
    if (w_pattern) begin
      w_run_next = (r_run_cnt == {RUN_CNT_W{1'b1}}) ? r_run_cnt : r_run_cnt + 1'b1;
    end
  end

  // Halt wins over timeout when both land on the same cycle.
  assign w_halt_hit = w_run && w_pattern && (w_run_next >= c_confirm);
  assign w_time_hit = w_run && !w_halt_hit && (w_cycles == c_cyc_limit);

  sat_counter #(.W(CNT_W)) u_cyc_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (w_run),
    .count (w_cycles)
  );

  sat_counter #(.W(CNT_W)) u_ret_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (w_run && retire_valid),
    .count (w_retired)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= RUN;
      r_run_cnt   <= '0;
      r_cyc_latch <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_run) begin
        r_run_cnt <= w_run_next;
        if (w_halt_hit || w_time_hit) begin
          r_cyc_latch <= w_cycles;
        end
        if (w_time_hit) begin
          r_timeout <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    rpt_valid    = 1'b0;
    rpt_data     = '0;
    rpt_last     = 1'b0;
    case (r_state)
      RUN: begin
        if (w_halt_hit || w_time_hit) begin
          w_state_next = SEND_CYC;
        end
      end
      SEND_CYC: begin
        rpt_valid = 1'b1;
        rpt_data  = r_cyc_latch;
        if (rpt_ready) begin
          w_state_next = SEND_RET;
        end
      end
      SEND_RET: begin
        rpt_valid = 1'b1;
        rpt_data  = w_retired;
        rpt_last  = 1'b1;
        if (rpt_ready) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_state_next = DONE;
      end
      default: begin
        w_state_next = RUN;
      end
    endcase
  end

  assign halted  = !w_run;
  assign timeout = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_halt_monitor.sv
// ============================================================================
// Module      : tb_halt_monitor
// Description : Directed self-checking bench for halt_monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_halt_monitor;

  logic        clk = 1'b0;
  logic        rst1 = 1'b0;
  logic        rst3 = 1'b0;
  logic [31:0] fetch = 32'h0;
  logic [31:0] decode = 32'h0;
  logic        retire = 1'b0;
  logic        rpt_ready = 1'b1;

  logic        halted1, timeout1, rpt_valid1, rpt_last1;
  logic [31:0] rpt_data1;
  logic        halted3, timeout3, rpt_valid3, rpt_last3;
  logic [31:0] rpt_data3;

  int checks = 0;
  int failures = 0;
  int hs1 = 0;

  always #5 clk = ~clk;

  halt_monitor #(.CNT_W(32), .HALT_CONFIRM(1), .MAX_CYCLES(32'd100)) dut1 (
    .clk                (clk),
    .rst                (rst1),
    .fetch_instruction  (fetch),
    .decode_instruction (decode),
    .retire_valid       (retire),
    .halted             (halted1),
    .timeout            (timeout1),
    .rpt_valid          (rpt_valid1),
    .rpt_ready          (rpt_ready),
    .rpt_data           (rpt_data1),
    .rpt_last           (rpt_last1)
  );

  halt_monitor #(.CNT_W(32), .HALT_CONFIRM(3), .MAX_CYCLES(32'd5000)) dut3 (
    .clk                (clk),
    .rst                (rst3),
    .fetch_instruction  (fetch),
    .decode_instruction (decode),
    .retire_valid       (retire),
    .halted             (halted3),
    .timeout            (timeout3),
    .rpt_valid          (rpt_valid3),
    .rpt_ready          (rpt_ready),
    .rpt_data           (rpt_data3),
    .rpt_last           (rpt_last3)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the given inputs; returns #1 after the edge.
  task automatic cyc(input logic [31:0] f, input logic [31:0] d, input logic rv);
    fetch  = f;
    decode = d;
    retire = rv;
    #1;
    if (rpt_valid1 && rpt_ready) hs1++;
    @(posedge clk);
    #1;
  endtask

  task automatic reset1();
    rst1 = 1'b0;
    cyc(32'h13, 32'h13, 1'b0);
    cyc(32'h13, 32'h13, 1'b0);
    hs1 = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_halted",  {63'd0, halted1},    64'd0);
    check("reset_timeout", {63'd0, timeout1},   64'd0);
    check("reset_valid",   {63'd0, rpt_valid1}, 64'd0);
    check("reset_data",    {32'd0, rpt_data1},  64'd0);

    // Halt at cycle 40, retires in cycles 16..40 (25), one fetch=6F/decode=13 decoy.
    rst1 = 1'b1;
    for (int k = 0; k <= 40; k++) begin
      if (k == 40)     cyc(32'h6F, 32'h0,  1'b1);
      else if (k == 5) cyc(32'h6F, 32'h13, 1'b0);
      else             cyc(32'h13, 32'h13, k >= 16);
      if (k == 5)  check("decoy_no_halt", {63'd0, halted1}, 64'd0);
      if (k == 39) check("pre_halt_valid", {63'd0, rpt_valid1}, 64'd0);
    end
    check("a_valid",   {63'd0, rpt_valid1}, 64'd1);
    check("a_cycles",  {32'd0, rpt_data1},  64'd40);
    check("a_last0",   {63'd0, rpt_last1},  64'd0);
    check("a_halted",  {63'd0, halted1},    64'd1);
    check("a_timeout", {63'd0, timeout1},   64'd0);
    cyc(32'h0, 32'h0, 1'b1);
    check("a_retired", {32'd0, rpt_data1},  64'd25);
    check("a_last1",   {63'd0, rpt_last1},  64'd1);
    cyc(32'h6F, 32'h0, 1'b1);
    check("a_done_valid",  {63'd0, rpt_valid1}, 64'd0);
    check("a_done_halted", {63'd0, halted1},    64'd1);
    cyc(32'h6F, 32'h0, 1'b1);
    check("a_done_stay", {63'd0, rpt_valid1}, 64'd0);

    // Timeout with MAX_CYCLES=100.
    reset1();
    check("b_reset_halted", {63'd0, halted1}, 64'd0);
    rst1 = 1'b1;
    for (int k = 0; k <= 99; k++) begin
      cyc(32'h13, 32'h13, 1'b0);
      if (k == 98) check("b_pre_timeout", {63'd0, halted1}, 64'd0);
    end
    check("b_timeout", {63'd0, timeout1},  64'd1);
    check("b_halted",  {63'd0, halted1},   64'd1);
    check("b_cycles",  {32'd0, rpt_data1}, 64'd99);
    cyc(32'h13, 32'h13, 1'b0);
    check("b_retired", {32'd0, rpt_data1}, 64'd0);
    check("b_last",    {63'd0, rpt_last1}, 64'd1);

    // Halt and timeout on the same cycle: halt wins.
    reset1();
    rst1 = 1'b1;
    for (int k = 0; k <= 99; k++) begin
      if (k == 99) cyc(32'h6F, 32'h0, 1'b0);
      else         cyc(32'h13, 32'h13, 1'b0);
    end
    check("f_timeout", {63'd0, timeout1},  64'd0);
    check("f_cycles",  {32'd0, rpt_data1}, 64'd99);

    // Backpressure in SEND_CYC for 5 cycles, then exactly two handshakes.
    reset1();
    rst1 = 1'b1;
    rpt_ready = 1'b0;
    for (int k = 0; k <= 7; k++) begin
      if (k == 7) cyc(32'h6F, 32'h0,  1'b0);
      else        cyc(32'h13, 32'h13, k < 3);
    end
    for (int k = 0; k < 5; k++) begin
      check("c_hold_valid", {63'd0, rpt_valid1}, 64'd1);
      check("c_hold_data",  {32'd0, rpt_data1},  64'd7);
      check("c_hold_last",  {63'd0, rpt_last1},  64'd0);
      cyc(32'h13, 32'h13, 1'b1);
    end
    rpt_ready = 1'b1;
    cyc(32'h13, 32'h13, 1'b1);
    check("c_retired", {32'd0, rpt_data1}, 64'd3);
    for (int k = 0; k < 4; k++) cyc(32'h13, 32'h13, 1'b0);
    check("c_handshakes", 64'(hs1), 64'd2);
    check("c_done_valid", {63'd0, rpt_valid1}, 64'd0);

    // Reset in SEND_RET, then a fresh run halting at cycle 7.
    reset1();
    rst1 = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      if (k == 7) cyc(32'h6F, 32'h0,  1'b1);
      else        cyc(32'h13, 32'h13, 1'b1);
    end
    rpt_ready = 1'b0;
    cyc(32'h13, 32'h13, 1'b0);
    rpt_ready = 1'b1;
    cyc(32'h13, 32'h13, 1'b0);
    rpt_ready = 1'b0;
    cyc(32'h13, 32'h13, 1'b0);
    check("d_in_send_ret", {63'd0, rpt_last1}, 64'd1);
    rst1 = 1'b0;
    cyc(32'h13, 32'h13, 1'b0);
    check("d_rst_valid",   {63'd0, rpt_valid1}, 64'd0);
    check("d_rst_data",    {32'd0, rpt_data1},  64'd0);
    check("d_rst_last",    {63'd0, rpt_last1},  64'd0);
    check("d_rst_halted",  {63'd0, halted1},    64'd0);
    check("d_rst_timeout", {63'd0, timeout1},   64'd0);
    rst1 = 1'b1;
    rpt_ready = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      if (k == 7) cyc(32'h6F, 32'h0,  1'b0);
      else        cyc(32'h13, 32'h13, 1'b0);
    end
    check("d_fresh_cycles", {32'd0, rpt_data1}, 64'd7);
    check("d_fresh_halted", {63'd0, halted1},   64'd1);

    // HALT_CONFIRM=3: broken run at 10-11, confirmed run at 20-22.
    rst1 = 1'b0;
    rst3 = 1'b1;
    for (int k = 0; k <= 22; k++) begin
      if (k == 10 || k == 11 || (k >= 20 && k <= 22)) cyc(32'h6F, 32'h0, 1'b0);
      else                                             cyc(32'h13, 32'h13, 1'b0);
      if (k == 12) check("e_gap_no_halt", {63'd0, halted3}, 64'd0);
      if (k == 21) check("e_two_no_halt", {63'd0, halted3}, 64'd0);
    end
    check("e_halted", {63'd0, halted3},   64'd1);
    check("e_cycles", {32'd0, rpt_data3}, 64'd22);
    check("e_timeout", {63'd0, timeout3}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
